// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, start-edge detect, mid-bit sampling.
// rx_data is updated only on a correctly framed byte; rx_valid / frame_err are one-cycle strobes.
module uart_rx #(
    parameter int BAUD_DIV = 5208,
    parameter int HALF     = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic            rxs_prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;

    // Synchroniser and edge history preset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // Handshake: rx_valid is a single-cycle strobe with no backpressure; the
    // consumer must capture rx_data in that cycle (rx_data then holds until the
    // next good frame). frame_err is an equally short strobe and never overlaps it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a genuine 1->0 transition starts a frame, so a held break cannot retrigger.
                    if (rxs_prev && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_cnt] <= rxs;
                        bit_cnt            <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at the stop mid-sample so a back-to-back start edge is not missed.
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rxs) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at BAUD_DIV=16 for the scenario list, one at the default divider.
// Expected pulses are queued at stimulus time and popped by a negedge monitor.
module tb_uart_rx;

    localparam int BD     = 16;
    localparam int HALF   = BD / 2;
    localparam int BD_DEF = 5208;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_def;
    logic       rx;
    logic       rx_def;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] rx_data_def;
    logic       rx_valid_def;
    logic       frame_err_def;
    logic       busy_def;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Scoreboard entries: {is_frame_err, expected rx_data}
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_def_q[$];
    int unsigned t_valid[$];
    int unsigned t_start;
    logic [7:0]  last_data;
    logic [8:0]  mon_e;
    logic [8:0]  mon_def_e;

    uart_rx #(.BAUD_DIV(BD)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    uart_rx u_dut_def (
        .clk       (clk),
        .rst       (rst_def),
        .rx        (rx_def),
        .rx_data   (rx_data_def),
        .rx_valid  (rx_valid_def),
        .frame_err (frame_err_def),
        .busy      (busy_def)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit on_def, input logic v);
        if (on_def) rx_def = v;
        else        rx = v;
    endtask

    task automatic send_byte(input bit on_def, input int bd, input logic [7:0] d,
                             input logic stop_bit, input bit chk_busy);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(on_def, frame[i]);
            if (i == 0 && !on_def) t_start = cyc;
            if (chk_busy && i == 4) begin
                wait_cyc(bd / 2);
                check(on_def ? "def_busy_mid" : "busy_mid", on_def ? busy_def : busy, 1);
                wait_cyc(bd - bd / 2);
            end else begin
                wait_cyc(bd);
            end
        end
        drive(on_def, 1'b1);
    endtask

    task automatic drain(input bit on_def);
        for (int i = 0; i < 40; i++) begin
            if ((on_def ? exp_def_q.size() : exp_q.size()) == 0) break;
            wait_cyc(1);
        end
        check(on_def ? "def_drain" : "drain", on_def ? exp_def_q.size() : exp_q.size(), 0);
    endtask

    // Monitors / scoreboard pop
    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            check("exclusive", {31'd0, rx_valid & frame_err}, 0);
            if (exp_q.size() == 0) begin
                check("unexp_valid", {31'd0, rx_valid}, 0);
                check("unexp_err", {31'd0, frame_err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("kind", {31'd0, frame_err}, {31'd0, mon_e[8]});
                check("data", {24'd0, rx_data}, {24'd0, mon_e[7:0]});
            end
            if (rx_valid) t_valid.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rx_valid_def || frame_err_def) begin
            if (exp_def_q.size() == 0) begin
                check("def_unexp_valid", {31'd0, rx_valid_def}, 0);
                check("def_unexp_err", {31'd0, frame_err_def}, 0);
            end else begin
                mon_def_e = exp_def_q.pop_front();
                check("def_kind", {31'd0, frame_err_def}, {31'd0, mon_def_e[8]});
                check("def_data", {24'd0, rx_data_def}, {24'd0, mon_def_e[7:0]});
            end
        end
    end

    initial begin
        #(10 * 150000);
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        rst_def = 1'b1;
        rx = 1'b1;
        rx_def = 1'b1;
        last_data = 8'h00;
        t_start = 0;
        wait_cyc(4);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_def_busy", busy_def, 0);
        rst = 1'b0;
        rst_def = 1'b0;
        wait_cyc(4);

        fork
            begin
                exp_def_q.push_back({1'b0, 8'h61});
                send_byte(1'b1, BD_DEF, 8'h61, 1'b1, 1'b1);
                drain(1'b1);
                check("def_hold", rx_data_def, 8'h61);
                check("def_busy_end", busy_def, 0);
            end
            begin
                // Single frame with latency measurement
                t_valid.delete();
                exp_q.push_back({1'b0, 8'h61});
                last_data = 8'h61;
                send_byte(1'b0, BD, 8'h61, 1'b1, 1'b1);
                drain(1'b0);
                check("single_pulses", t_valid.size(), 1);
                if (t_valid.size() >= 1)
                    check("latency", t_valid[0] - t_start, 3 + HALF + 9 * BD);
                check("busy_end", busy, 0);

                // Start glitch
                rx = 1'b0;
                wait_cyc(4);
                rx = 1'b1;
                wait_cyc(2);
                check("glitch_busy", busy, 1);
                wait_cyc(20);
                check("glitch_idle", busy, 0);
                check("glitch_data", rx_data, last_data);

                // Bad stop bit
                exp_q.push_back({1'b1, last_data});
                send_byte(1'b0, BD, 8'hA5, 1'b0, 1'b0);
                drain(1'b0);
                check("badstop_hold", rx_data, 8'h61);
                wait_cyc(20);

                // Back-to-back
                t_valid.delete();
                exp_q.push_back({1'b0, 8'h55});
                send_byte(1'b0, BD, 8'h55, 1'b1, 1'b0);
                exp_q.push_back({1'b0, 8'hAA});
                send_byte(1'b0, BD, 8'hAA, 1'b1, 1'b0);
                drain(1'b0);
                last_data = 8'hAA;
                check("b2b_pulses", t_valid.size(), 2);
                if (t_valid.size() >= 2)
                    check("b2b_spacing", t_valid[1] - t_valid[0], 10 * BD);

                // Break: one frame_err, no retrigger while low
                exp_q.push_back({1'b1, last_data});
                rx = 1'b0;
                wait_cyc(30 * BD);
                check("break_idle", busy, 0);
                rx = 1'b1;
                wait_cyc(2 * BD);
                drain(1'b0);
                exp_q.push_back({1'b0, 8'h3C});
                send_byte(1'b0, BD, 8'h3C, 1'b1, 1'b0);
                drain(1'b0);
                last_data = 8'h3C;

                // Reset during data bit 4 of 0xFF
                rx = 1'b0;
                wait_cyc(BD);
                rx = 1'b1;
                wait_cyc(4 * BD + BD / 2);
                check("abort_busy", busy, 1);
                rst = 1'b1;
                wait_cyc(3);
                check("abort_rst_data", rx_data, 8'h00);
                check("abort_rst_busy", busy, 0);
                rst = 1'b0;
                last_data = 8'h00;
                wait_cyc(6 * BD);
                check("abort_idle", busy, 0);
                exp_q.push_back({1'b0, 8'h12});
                send_byte(1'b0, BD, 8'h12, 1'b1, 1'b0);
                drain(1'b0);
                last_data = 8'h12;

                // Random bytes
                for (int k = 0; k < 4; k++) begin
                    d = 8'($urandom_range(0, 255));
                    exp_q.push_back({1'b0, d});
                    send_byte(1'b0, BD, d, 1'b1, 1'b0);
                    drain(1'b0);
                    last_data = d;
                    check("rand_hold", rx_data, last_data);
                end
            end
        join

        check("sb_empty", exp_q.size() + exp_def_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
